wb_ctrl: RTL

// - Writeback stage directly upstream of the general register file. Merges ALU results from ex
//   and load responses from the LSU into the single register-file write port (we/waddr/wdata).
// - Performs load byte/half extraction with sign/zero extension.
// - Keeps a pending-load scoreboard so id can detect RAW hazards on registers awaiting load data.

---
 rtl/wb_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wb_ctrl.sv
// Writeback merge of LSU load data and ex results into the regfile write port, with a pending-load scoreboard.
// Output is registered one cycle after select. ex stalls only while the 1-entry hold buffer is full. WB_RETIRE_CNT_EN adds retire_cnt_o.
module wb_ctrl #(
   parameter int LdOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ex_valid_i,
   output logic        ex_ready_o,
   input  logic [4:0]  ex_rd_i,
   input  logic [31:0] ex_data_i,
   input  logic        ld_issue_i,
   input  logic [4:0]  ld_issue_rd_i,
   output logic        ld_ready_o,
   input  logic        lsu_rvalid_i,
   input  logic [4:0]  lsu_rd_i,
   input  logic [2:0]  lsu_funct3_i,
   input  logic [1:0]  lsu_off_i,
   input  logic [31:0] lsu_rdata_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   output logic        hazard_o,
   output logic [31:0] busy_o,
   output logic        we_o,
   output logic [4:0]  waddr_o,
   output logic [31:0] wdata_o
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [63:0] retire_cnt_o
`endif
);

   localparam logic [2:0] LdMax = 3'(LdOutstanding);

   logic        hold_valid_q, hold_valid_d;
   logic [4:0]  hold_rd_q, hold_rd_d;
   logic [31:0] hold_data_q, hold_data_d;
   logic [31:0] busy_q, busy_d;
   logic [2:0]  pend_cnt_q, pend_cnt_d;
   logic        we_q, we_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;

   logic        ex_acc, ld_acc;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic        sel_vld;

   assign ex_ready_o = ~hold_valid_q;
   assign ld_ready_o = (pend_cnt_q < LdMax);
   assign ex_acc     = ex_valid_i & ex_ready_o;
   assign ld_acc     = ld_issue_i & ld_ready_o;
   assign hazard_o   = busy_q[rs1_i] | busy_q[rs2_i];
   assign busy_o     = busy_q;
   assign we_o       = we_q;
   assign waddr_o    = waddr_q;
   assign wdata_o    = wdata_q;

   always_comb begin
      case (lsu_off_i)
         2'd0:    ld_byte = lsu_rdata_i[7:0];
         2'd1:    ld_byte = lsu_rdata_i[15:8];
         2'd2:    ld_byte = lsu_rdata_i[23:16];
         default: ld_byte = lsu_rdata_i[31:24];
      endcase
      ld_half = lsu_off_i[1] ? lsu_rdata_i[31:16] : lsu_rdata_i[15:0];
      case (lsu_funct3_i)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = lsu_rdata_i;
      endcase
   end

   // Load data always wins the port; a colliding ex result parks in the hold buffer.
   always_comb begin
      sel_vld     = 1'b0;
      waddr_d     = 5'd0;
      wdata_d     = 32'd0;
      hold_valid_d = hold_valid_q;
      hold_rd_d   = hold_rd_q;
      hold_data_d = hold_data_q;
      if (lsu_rvalid_i) begin
         sel_vld = 1'b1;
         waddr_d = lsu_rd_i;
         wdata_d = ld_data;
         if (ex_acc) begin
            hold_valid_d = 1'b1;
            hold_rd_d    = ex_rd_i;
            hold_data_d  = ex_data_i;
         end
      end else if (hold_valid_q) begin
         sel_vld      = 1'b1;
         waddr_d      = hold_rd_q;
         wdata_d      = hold_data_q;
         hold_valid_d = 1'b0;
      end else if (ex_acc) begin
         sel_vld = 1'b1;
         waddr_d = ex_rd_i;
         wdata_d = ex_data_i;
      end
      we_d = sel_vld && (waddr_d != 5'd0);
   end

   always_comb begin
      busy_d = busy_q;
      if (lsu_rvalid_i) busy_d[lsu_rd_i] = 1'b0;
      if (ld_acc && ld_issue_rd_i != 5'd0) busy_d[ld_issue_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
      pend_cnt_d = pend_cnt_q;
      if (ld_acc && !lsu_rvalid_i) pend_cnt_d = pend_cnt_q + 3'd1;
      else if (!ld_acc && lsu_rvalid_i && pend_cnt_q != 3'd0) pend_cnt_d = pend_cnt_q - 3'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_valid_q <= 1'b0;
         hold_rd_q    <= 5'd0;
         hold_data_q  <= 32'd0;
         busy_q       <= 32'd0;
         pend_cnt_q   <= 3'd0;
         we_q         <= 1'b0;
         waddr_q      <= 5'd0;
         wdata_q      <= 32'd0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_rd_q    <= hold_rd_d;
         hold_data_q  <= hold_data_d;
         busy_q       <= busy_d;
         pend_cnt_q   <= pend_cnt_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [63:0] retire_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) retire_q <= 64'd0;
      else       retire_q <= retire_q + {63'd0, we_q};
   end
   assign retire_cnt_o = retire_q;
`endif

`ifndef SYNTHESIS
   a_ex_busy_rd: assert property (@(posedge clk_i) disable iff (rst_i)
      !(ex_acc && ex_rd_i != 5'd0 && busy_q[ex_rd_i]));
   a_ld_busy_rd: assert property (@(posedge clk_i) disable iff (rst_i)
      !(ld_acc && ld_issue_rd_i != 5'd0 && busy_q[ld_issue_rd_i]));
   a_rsp_no_pend: assert property (@(posedge clk_i) disable iff (rst_i)
      !(lsu_rvalid_i && pend_cnt_q == 3'd0));
`endif

endmodule
